// File: rtl/mem_access_unit_if.sv
// Data-memory port of the MEM stage: a valid/ready request channel plus a read-response
// channel that the unit never throttles.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        resp_valid;
  logic [31:0] rdata;

  modport master (
    output req_valid, we, addr, wdata, be,
    input  req_ready, resp_valid, rdata
  );

  modport slave (
    input  req_valid, we, addr, wdata, be,
    output req_ready, resp_valid, rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one data-memory request per op, stalls the pipeline
// until the op retires, and returns zero-extended load data for register writeback.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic              clk,
  input  logic              n_reset_i,
  input  logic              valid_i,
  input  logic              is_mem_op_i,
  input  logic              is_store_op_i,
  input  logic              is_byte_op_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       store_data_i,
  input  logic [4:0]        rd_addr_i,
  output logic              stall_o,
  output logic              load_valid_o,
  output logic [31:0]       load_data_o,
  output logic [4:0]        load_rd_o,
  output logic              misaligned_o,
  output logic              timeout_o,
  mem_access_unit_if.master dmem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  localparam bit                TMO_EN       = (TIMEOUT_CYCLES != 0);
  localparam int unsigned       TMO_LAST_INT = TMO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0]  TMO_LAST     = TMO_LAST_INT[CNT_W-1:0];

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q;
  logic              req_valid_q;
  logic              we_q;
  logic              byte_q;
  logic [29:0]       addr_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [4:0]        rd_q;
  logic              load_valid_q;
  logic              misaligned_q;
  logic              timeout_q;
  logic [31:0]       load_data_q;
  logic [4:0]        load_rd_q;

  logic              accept;
  logic              misaligned_in;
  logic [31:0]       wdata_next;
  logic [3:0]        be_next;
  logic [7:0]        resp_byte;
  logic [31:0]       resp_data;

  // Gated by reset so the combinational stall is also low while the unit is held in reset.
  assign accept        = (state == S_IDLE) && valid_i && is_mem_op_i && n_reset_i;
  assign misaligned_in = !is_byte_op_i && (addr_i[1:0] != 2'b00);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    wdata_next = store_data_i;
    be_next    = 4'hF;
    if (is_byte_op_i) begin
      wdata_next = {4{store_data_i[7:0]}};
      be_next    = 4'b0001 << addr_i[1:0];
    end
  end

  always_comb begin
    resp_byte = dmem.rdata[7:0];
    unique case (lane_q)
      2'd0: resp_byte = dmem.rdata[7:0];
      2'd1: resp_byte = dmem.rdata[15:8];
      2'd2: resp_byte = dmem.rdata[23:16];
      2'd3: resp_byte = dmem.rdata[31:24];
      default: resp_byte = dmem.rdata[7:0];
    endcase
  end

  assign resp_data = byte_q ? {24'b0, resp_byte} : dmem.rdata;

  always_ff @(posedge clk or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      busy_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      addr_q       <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rd_q         <= '0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
      load_data_q  <= '0;
      load_rd_q    <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= addr_i[31:2];
            lane_q  <= addr_i[1:0];
            byte_q  <= is_byte_op_i;
            we_q    <= is_store_op_i;
            wdata_q <= wdata_next;
            be_q    <= be_next;
            rd_q    <= rd_addr_i;
            if (misaligned_in) begin
              misaligned_q <= 1'b1;
              state        <= S_DONE;
            end else begin
              req_valid_q <= 1'b1;
              busy_q      <= 1'b1;
              state       <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (dmem.req_ready) begin
            req_valid_q <= 1'b0;
            cnt         <= '0;
            if (we_q) begin
              busy_q <= 1'b0;
              state  <= S_DONE;
            end else begin
              state  <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          // A response arriving in the last allowed cycle still completes the load.
          if (dmem.resp_valid) begin
            load_data_q  <= resp_data;
            load_rd_q    <= rd_q;
            load_valid_q <= 1'b1;
            busy_q       <= 1'b0;
            state        <= S_DONE;
          end else if (TMO_EN && (cnt == TMO_LAST)) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall_o      = busy_q || accept;
  assign load_valid_o = load_valid_q;
  assign load_data_o  = load_data_q;
  assign load_rd_o    = load_rd_q;
  assign misaligned_o = misaligned_q;
  assign timeout_o    = timeout_q;

  assign dmem.req_valid = req_valid_q;
  assign dmem.we        = we_q;
  assign dmem.addr      = addr_q;
  assign dmem.wdata     = wdata_q;
  assign dmem.be        = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected requests and completions are queued when an
// op is driven and popped when the unit issues the request or retires the op.
module tb_mem_access_unit;

  localparam int unsigned TMO = 4;

  typedef enum logic [1:0] {K_NONE, K_LOAD, K_MISAL, K_TMO} kind_e;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct packed {
    kind_e       kind;
    logic [31:0] data;
    logic [4:0]  rd;
  } done_t;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        valid, is_mem, is_store, is_byte;
  logic [31:0] addr, sdata;
  logic [4:0]  rd_addr;
  logic        stall, load_valid, misaligned, timeout;
  logic [31:0] load_data;
  logic [4:0]  load_rd;

  int checks = 0;
  int errors = 0;

  req_t  exp_req_q[$];
  done_t exp_done_q[$];

  mem_access_unit_if dmem();

  mem_access_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk          (clk),
    .n_reset_i    (n_reset),
    .valid_i      (valid),
    .is_mem_op_i  (is_mem),
    .is_store_op_i(is_store),
    .is_byte_op_i (is_byte),
    .addr_i       (addr),
    .store_data_i (sdata),
    .rd_addr_i    (rd_addr),
    .stall_o      (stall),
    .load_valid_o (load_valid),
    .load_data_o  (load_data),
    .load_rd_o    (load_rd),
    .misaligned_o (misaligned),
    .timeout_o    (timeout),
    .dmem         (dmem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_quiet_pulses(input string tag);
    check_bit({tag, "_load_valid"}, load_valid, 1'b0);
    check_bit({tag, "_misaligned"}, misaligned, 1'b0);
    check_bit({tag, "_timeout"},    timeout,    1'b0);
  endtask

  // Runs one op from IDLE to retirement; called and returning on a falling edge.
  // rdy_dly: REQ cycles with ready low; resp_dly: WAIT cycle index of the response (-1 none).
  task automatic do_op(input string tag, input bit st, input bit by, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd, input int rdy_dly,
                       input int resp_dly, input logic [31:0] rdata);
    bit    mis, done;
    int    exp_stall, stall_n, hs, seen, widx;
    req_t  er;
    done_t ed;

    mis = !by && (a[1:0] != 2'b00);
    if (!mis) begin
      er.we    = st;
      er.addr  = a[31:2];
      er.wdata = by ? {4{d[7:0]}} : d;
      er.be    = by ? (4'b0001 << a[1:0]) : 4'hF;
      exp_req_q.push_back(er);
    end
    ed.rd   = rd;
    ed.data = by ? ((rdata >> {a[1:0], 3'b000}) & 32'h0000_00FF) : rdata;
    if (mis) begin
      ed.kind = K_MISAL; exp_stall = 1;
    end else if (st) begin
      ed.kind = K_NONE;  exp_stall = 2 + rdy_dly;
    end else if (resp_dly >= 0 && resp_dly < int'(TMO)) begin
      ed.kind = K_LOAD;  exp_stall = 3 + rdy_dly + resp_dly;
    end else begin
      ed.kind = K_TMO;   exp_stall = 2 + rdy_dly + int'(TMO);
    end
    exp_done_q.push_back(ed);

    valid = 1'b1; is_mem = 1'b1; is_store = st; is_byte = by;
    addr = a; sdata = d; rd_addr = rd;
    #1;
    check_bit({tag, "_idle_stall"}, stall, 1'b1);
    check_bit({tag, "_idle_req_valid"}, dmem.req_valid, 1'b0);
    stall_n = 1; hs = 0; seen = 0; widx = 0; done = 1'b0;

    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (dmem.req_valid) begin
        if (exp_req_q.size() == 0) begin
          check({tag, "_unexpected_req"}, 32'(dmem.req_valid), 32'd0);
        end else begin
          er = exp_req_q[0];
          check_bit({tag, "_req_we"}, dmem.we, er.we);
          check({tag, "_req_addr"},  32'(dmem.addr), 32'(er.addr));
          check({tag, "_req_wdata"}, dmem.wdata, er.wdata);
          check({tag, "_req_be"},    32'(dmem.be), 32'(er.be));
          check_bit({tag, "_req_stall"}, stall, 1'b1);
          if (seen >= rdy_dly) dmem.req_ready = 1'b1;
          seen++;
          if (dmem.req_ready) begin
            hs++;
            void'(exp_req_q.pop_front());
          end
        end
      end else if (stall && hs > 0) begin
        dmem.resp_valid = (widx == resp_dly);
        dmem.rdata      = (widx == resp_dly) ? rdata : $urandom();
        widx++;
      end else if (!stall) begin
        done = 1'b1;
        dmem.resp_valid = 1'b0;
        dmem.req_ready  = 1'b0;
        valid = 1'b0; is_mem = 1'b0;
        if (exp_done_q.size() == 0) begin
          check({tag, "_done_queue"}, 32'd0, 32'd1);
        end else begin
          ed = exp_done_q.pop_front();
          check_bit({tag, "_load_valid"}, load_valid, ed.kind == K_LOAD);
          check_bit({tag, "_misaligned"}, misaligned, ed.kind == K_MISAL);
          check_bit({tag, "_timeout"},    timeout,    ed.kind == K_TMO);
          if (ed.kind == K_LOAD) begin
            check({tag, "_load_data"}, load_data, ed.data);
            check({tag, "_load_rd"},   32'(load_rd), 32'(ed.rd));
          end
        end
      end
    end

    if (!done) begin
      check({tag, "_retire_within_budget"}, 32'd0, 32'd1);
      exp_req_q.delete();
      exp_done_q.delete();
      valid = 1'b0; is_mem = 1'b0;
      dmem.req_ready = 1'b0; dmem.resp_valid = 1'b0;
    end else begin
      check({tag, "_stall_cycles"}, stall_n, exp_stall);
      check({tag, "_handshakes"},   hs, mis ? 0 : 1);
    end

    @(negedge clk);
    check_quiet_pulses({tag, "_after"});
    check_bit({tag, "_after_stall"}, stall, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset = 1'b0;
    valid = 1'b0; is_mem = 1'b0; is_store = 1'b0; is_byte = 1'b0;
    addr = '0; sdata = '0; rd_addr = '0;
    dmem.req_ready = 1'b0; dmem.resp_valid = 1'b0; dmem.rdata = '0;

    #12;
    check_bit("rst_stall", stall, 1'b0);
    check_bit("rst_req_valid", dmem.req_valid, 1'b0);
    check_quiet_pulses("rst");
    check("rst_load_data", load_data, 32'd0);
    check("rst_req_be", 32'(dmem.be), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    valid = 1'b1; is_mem = 1'b0;
    #1;
    check_bit("non_mem_stall", stall, 1'b0);
    @(negedge clk);
    check_bit("non_mem_req_valid", dmem.req_valid, 1'b0);
    check_bit("non_mem_stall_held", stall, 1'b0);
    valid = 1'b0;

    do_op("sw_word",          1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0,  0,  0, 32'h0);
    do_op("lbu_lane3",        1'b0, 1'b1, 32'h0000_0203, 32'h0,         5'd9,  0,  0, 32'hAABB_CCDD);
    do_op("sb_lane1",         1'b1, 1'b1, 32'h0000_0001, 32'h1234_5678, 5'd0,  0,  0, 32'h0);
    do_op("sw_ready_late",    1'b1, 1'b0, 32'h0000_0044, 32'hCAFE_F00D, 5'd0,  3,  0, 32'h0);
    do_op("lw_misaligned",    1'b0, 1'b0, 32'h0000_0006, 32'h0,         5'd3,  0,  0, 32'h1111_1111);
    do_op("sw_misaligned",    1'b1, 1'b0, 32'h0000_0002, 32'h0000_0055, 5'd0,  0,  0, 32'h0);
    do_op("lw_delayed",       1'b0, 1'b0, 32'h0000_1000, 32'h0,         5'd17, 2,  2, 32'h89AB_CDEF);
    do_op("lbu_lane0",        1'b0, 1'b1, 32'h0000_0400, 32'h0,         5'd1,  0,  1, 32'h1122_3344);
    do_op("lbu_lane2",        1'b0, 1'b1, 32'h0000_0402, 32'h0,         5'd2,  1,  0, 32'h1122_3344);
    do_op("lw_resp_at_limit", 1'b0, 1'b0, 32'h0000_0020, 32'h0,         5'd31, 0, int'(TMO) - 1, 32'h0F0F_1234);
    do_op("lw_timeout",       1'b0, 1'b0, 32'h0000_0024, 32'h0,         5'd4,  0, -1, 32'h0);

    // A response after the timeout must not retire anything or disturb the held load result.
    dmem.resp_valid = 1'b1; dmem.rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem.resp_valid = 1'b0;
    check_quiet_pulses("late_resp");
    check("late_resp_load_data_held", load_data, 32'h0F0F_1234);
    check("late_resp_load_rd_held", 32'(load_rd), 32'd31);
    check_bit("late_resp_stall", stall, 1'b0);

    // Reset asserted while a load waits for its response.
    valid = 1'b1; is_mem = 1'b1; is_store = 1'b0; is_byte = 1'b0;
    addr = 32'h0000_0300; rd_addr = 5'd7;
    @(negedge clk);
    check_bit("rst_wait_req_valid", dmem.req_valid, 1'b1);
    dmem.req_ready = 1'b1;
    @(negedge clk);
    dmem.req_ready = 1'b0;
    check_bit("rst_wait_in_wait_stall", stall, 1'b1);
    #2 n_reset = 1'b0;
    #1;
    check_bit("rst_wait_stall", stall, 1'b0);
    check_bit("rst_wait_req_valid_low", dmem.req_valid, 1'b0);
    check_quiet_pulses("rst_wait");
    check("rst_wait_load_data", load_data, 32'd0);
    check("rst_wait_load_rd", 32'(load_rd), 32'd0);
    @(negedge clk);
    valid = 1'b0; is_mem = 1'b0;
    n_reset = 1'b1;
    dmem.resp_valid = 1'b1; dmem.rdata = 32'hDEAD_DEAD;
    @(negedge clk);
    dmem.resp_valid = 1'b0;
    check_quiet_pulses("post_rst_resp");
    check("post_rst_resp_load_data", load_data, 32'd0);
    check_bit("post_rst_resp_stall", stall, 1'b0);
    @(negedge clk);

    do_op("lw_after_reset", 1'b0, 1'b0, 32'h0000_0300, 32'h0, 5'd7, 0, 0, 32'h600D_CAFE);

    check("scoreboard_drained", exp_req_q.size() + exp_done_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
